spi_burst_arbiter: RTL and testbench
====================================

Name: spi_burst_arbiter

Overview:
- Shares one spi_master byte engine between NREQ requesters: CPU peripheral, motor/sensor pollers.
- Grants the engine round-robin and runs a multi-byte burst per grant.
- Holds that requester's device chip-select low for the whole burst; the engine's own ss only frames single bytes.
- Sits between the requesters and the spi_master instance; drives its data_in/start and consumes busy/new_data/data_out.

Parameters:
- NREQ, 3, number of requesters / device chip-selects (2..8).
- LEN_W, 4, width of burst length; max burst 2^LEN_W-1 bytes.
- TMO_W, 8, watchdog width; abort if no new_data within 2^TMO_W-1 cycles of start.
- GAP, 2, minimum cycles all cs_n stay high between bursts (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester burst request level.
- req_len  in  NREQ*LEN_W  burst length, requester i at [i*LEN_W +: LEN_W].
- req_tx  in  NREQ*8  next byte to send, requester i at [i*8 +: 8].
- grant  out  NREQ  one-hot owner of current burst.
- byte_done  out  1  one-cycle pulse: a byte finished, rx_data valid.
- rx_data  out  8  last received byte, held until next byte_done.
- done  out  1  one-cycle pulse: burst completed (normal, timeout or zero length).
- err  out  1  one-cycle pulse with done on watchdog abort.
- cs_n  out  NREQ  active-low device chip-selects.
- spi_data_in  out  8  byte to spi_master.
- spi_start  out  1  one-cycle start pulse to spi_master.
- spi_busy  in  1  spi_master busy.
- spi_new_data  in  1  spi_master byte-complete pulse.
- spi_data_out  in  8  spi_master received byte.

Behaviour:
- Reset values: grant=0, cs_n=all ones, byte_done=done=err=spi_start=0, rx_data=0, spi_data_in=0, rr pointer=0, state IDLE.
- States: IDLE, LOAD, WAIT, FIN, GAP.
- IDLE:
  - If any req is set, choose the first set bit at or after the rr pointer, wrapping.
  - Latch len and set grant next cycle.
  - len=0: go to FIN directly; cs_n is never asserted.
  - len>0: drive cs_n[i]=0 and go to LOAD.
- LOAD (one cycle):
  - spi_data_in <= req_tx of the granted requester; spi_start=1 for exactly one cycle.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - Ignore spi_busy for the first cycle after start; the engine registers start on negedge.
  - On spi_new_data: rx_data <= spi_data_out, byte_done pulse, count decrements.
  - If count becomes 0 → FIN, else → LOAD.
  - The requester must present its next byte on req_tx by the cycle after byte_done.
  - If the watchdog reaches all ones: err=1, go to FIN; remaining bytes are dropped.
- FIN (one cycle):
  - done=1; cs_n all high; grant=0.
  - rr pointer <= granted index+1, modulo NREQ.
  - Go to GAP.
- GAP: hold GAP cycles with all cs_n high, then return to IDLE.
- Request sampling:
  - req is sampled only in IDLE.
  - Deasserting req mid-burst does not shorten the burst.
  - req still high at return to IDLE starts a new burst, subject to rr fairness.
- Simultaneous requests: strict rotation; no requester is granted twice while another waits.
- Chip-select: at most one cs_n bit is low at any time; cs_n falls one cycle before the first spi_start.
- Reset mid-burst: immediate return to reset values. spi_master is reset by the same rst, so no partial byte is reported.
- spi_new_data outside WAIT is ignored.

Decomposition:
- Shared package spi_ctrl_pkg: state encoding constants and a default GAP constant.
- Natural sub-module: spi_rr_picker, a combinational round-robin one-hot selector from req and pointer. It is reused by future bus arbiters.

Test Plan:
- Single burst: req[0]=1, len=1, tx=8'hA5, slave returns 8'h3C → cs_n[0] low, one spi_start with data 8'hA5, byte_done with rx_data=8'h3C, then done; cs_n back to 3'b111.
- Three-byte burst: req[1], len=3, tx 8'h01,8'h02,8'h03 → three spi_start pulses in order, cs_n[1] low continuously, done after the third byte_done.
- Simultaneous: req=3'b111, each len=1, held → grant order 001,010,100,001; at least GAP cycles with cs_n=111 between bursts.
- Zero length: req[2], len=0 → done within 3 cycles, no spi_start, cs_n never low.
- Timeout: spi_new_data held 0 → err and done pulse 255 cycles after start (TMO_W=8); cs_n released.
- Reset mid-burst: rst during byte 2 of 3 → cs_n=111, grant=0, no done or byte_done. After release, a new req is served normally.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI burst controller slice: FSM state encoding
// and the default inter-burst chip-select gap.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_FIN,
    ST_GAP
  } spi_state_e;

  localparam int unsigned SPI_GAP_DEFAULT = 2;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin selector: one-hot grant and index of the first
// set request at or after ptr, wrapping modulo N.
module spi_rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int unsigned   pos;
  logic [PW-1:0] p;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    p   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      p   = PW'(pos);
      if (!any && req[p]) begin
        any    = 1'b1;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine between requesters,
// running a multi-byte burst per grant under a held device chip-select.
module spi_burst_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned TMO_W = 8,
  parameter int unsigned GAP   = SPI_GAP_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ*8-1:0]       req_tx,
  output logic [NREQ-1:0]         grant,
  output logic                    byte_done,
  output logic [7:0]              rx_data,
  output logic                    done,
  output logic                    err,
  output logic [NREQ-1:0]         cs_n,
  output logic [7:0]              spi_data_in,
  output logic                    spi_start,
  input  logic                    spi_busy,
  input  logic                    spi_new_data,
  input  logic [7:0]              spi_data_out
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  spi_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, gidx_q, fin_idx, nxt_ptr, pick_idx;
  logic [NREQ-1:0]   pick_gnt;
  logic              pick_any, tmo, enter_fin;
  logic [LEN_W-1:0]  cnt_q, len_sel;
  logic [TMO_W-1:0]  wd_q;
  logic [GW-1:0]     gap_q;
  logic [7:0]        tx_sel;

  spi_rr_picker #(.N(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    len_sel = '0;
    tx_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) len_sel = req_len[i*LEN_W +: LEN_W];
      if (gidx_q == PW'(i))   tx_sel  = req_tx[i*8 +: 8];
    end
  end

  // Watchdog reaches all ones on the edge that ends this cycle; a byte
  // arriving in the same cycle still wins.
  assign tmo = (state_q == ST_WAIT) && !spi_new_data && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_any) state_d = (len_sel == '0) ? ST_FIN : ST_LOAD;
      ST_LOAD: if (!spi_busy) state_d = ST_WAIT;
      ST_WAIT: begin
        if (spi_new_data) state_d = (cnt_q == LEN_W'(1)) ? ST_FIN : ST_LOAD;
        else if (tmo)     state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_GAP;
      ST_GAP:  if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_fin = (state_d == ST_FIN) && (state_q != ST_FIN);
  assign fin_idx   = (state_q == ST_IDLE) ? pick_idx : gidx_q;
  assign nxt_ptr   = (fin_idx == PW'(NREQ - 1)) ? '0 : fin_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      cs_n        <= '1;
      byte_done   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      spi_start   <= 1'b0;
      rx_data     <= '0;
      spi_data_in <= '0;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      spi_start <= 1'b0;
      byte_done <= 1'b0;
      done      <= enter_fin;
      err       <= tmo;
      case (state_q)
        ST_IDLE: if (pick_any) begin
          gidx_q <= pick_idx;
          cnt_q  <= len_sel;
          if (len_sel != '0) begin
            grant <= pick_gnt;
            cs_n  <= ~pick_gnt;
          end
        end
        // Start is only issued into an idle engine.
        ST_LOAD: if (!spi_busy) begin
          spi_data_in <= tx_sel;
          spi_start   <= 1'b1;
          wd_q        <= '0;
        end
        ST_WAIT: begin
          wd_q <= wd_q + 1'b1;
          if (spi_new_data) begin
            rx_data   <= spi_data_out;
            byte_done <= 1'b1;
            cnt_q     <= cnt_q - 1'b1;
          end
        end
        ST_GAP: gap_q <= gap_q + 1'b1;
        default: ;
      endcase
      if (enter_fin) begin
        grant    <= '0;
        cs_n     <= '1;
        gap_q    <= '0;
        rr_ptr_q <= nxt_ptr;
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter with a small spi_master stand-in that
// answers each start after a fixed latency.
module tb_spi_burst_arbiter;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned TMO_W = 8;
  localparam int unsigned GAP   = 2;
  localparam int unsigned SLAVE_LAT = 4;

  logic                  clk, rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*8-1:0]     req_tx;
  logic [NREQ-1:0]       grant, cs_n;
  logic                  byte_done, done, err, spi_start;
  logic [7:0]            rx_data, spi_data_in, spi_data_out;
  logic                  spi_busy, spi_new_data;

  logic [7:0]            slave_resp;
  logic                  slave_mute;
  int unsigned           sl_cnt, sl_n;
  int unsigned           n_chk, n_fail;

  typedef struct packed {
    logic [NREQ-1:0]  req;
    logic [LEN_W-1:0] len;
    logic [7:0]       tx;
    logic [7:0]       resp;
    logic [NREQ-1:0]  exp_grant;
    logic [7:0]       exp_rx;
  } vec_t;

  vec_t vecs [5];

  spi_burst_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .TMO_W(TMO_W), .GAP(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_len      (req_len),
    .req_tx       (req_tx),
    .grant        (grant),
    .byte_done    (byte_done),
    .rx_data      (rx_data),
    .done         (done),
    .err          (err),
    .cs_n         (cs_n),
    .spi_data_in  (spi_data_in),
    .spi_start    (spi_start),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data),
    .spi_data_out (spi_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // spi_master stand-in: reset by the same rst, replies slave_resp+n per byte.
  initial begin
    spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = '0; sl_cnt = 0; sl_n = 0;
    forever begin
      @(negedge clk);
      spi_new_data = 1'b0;
      if (rst) begin
        spi_busy = 1'b0; sl_cnt = 0; sl_n = 0;
      end else begin
        if (done) begin spi_busy = 1'b0; sl_n = 0; end
        if (spi_start) begin
          spi_busy = 1'b1; sl_cnt = SLAVE_LAT;
        end else if (spi_busy && !slave_mute) begin
          sl_cnt--;
          if (sl_cnt == 0) begin
            spi_new_data = 1'b1;
            spi_data_out = slave_resp + 8'(sl_n);
            sl_n++;
            spi_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int unsigned starts, bds, t_cs, t_st, t_done;
    logic got_done, cs_seen, tx_bad, cs_bad, err_seen, post_bad;
    logic [NREQ-1:0] g_seen;
    logic [7:0] exp_tx;
    starts = 0; bds = 0; t_cs = 0; t_st = 0; t_done = 0;
    got_done = 0; cs_seen = 0; tx_bad = 0; cs_bad = 0; err_seen = 0; post_bad = 0;
    g_seen = '0;
    @(negedge clk);
    slave_resp = v.resp;
    req_len = {NREQ{v.len}};
    req_tx  = {NREQ{v.tx}};
    req     = v.req;
    exp_tx  = v.tx;
    for (int unsigned cyc = 1; cyc <= 400 && !got_done; cyc++) begin
      @(negedge clk);
      if (grant != '0 || done) req = '0;
      if (grant != '0) g_seen = grant;
      if (cs_n != '1) begin
        if (!cs_seen) t_cs = cyc;
        cs_seen = 1'b1;
        if (~cs_n != grant) cs_bad = 1'b1;
      end
      if (spi_start) begin
        if (starts == 0) t_st = cyc;
        starts++;
        if (spi_data_in != exp_tx) tx_bad = 1'b1;
      end
      if (byte_done) begin
        bds++;
        exp_tx = exp_tx + 8'd1;
        req_tx = {NREQ{exp_tx}};
      end
      if (done) begin got_done = 1'b1; t_done = cyc; err_seen = err; end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("grant", 32'(g_seen), 32'(v.exp_grant));
    chk("start_count", starts, 32'(v.len));
    chk("byte_done_count", bds, 32'(v.len));
    chk("rx_data", 32'(rx_data), 32'(v.exp_rx));
    chk("tx_order", 32'(tx_bad), 32'd0);
    chk("cs_matches_grant", 32'(cs_bad), 32'd0);
    chk("cs_asserted", 32'(cs_seen), 32'(v.len != '0));
    if (v.len != '0) chk("cs_lead_start", t_st - t_cs, 32'd1);
    else             chk("zero_len_latency", 32'(t_done <= 3), 32'd1);
    chk("err_normal", 32'(err_seen), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (cs_n != '1 || grant != '0) post_bad = 1'b1;
    end
    chk("released_after_done", 32'(post_bad), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] order [4];
    logic [NREQ-1:0] prev_g;
    int unsigned ng, nd, run, min_gap, starts, bds, t_st, t_done;
    logic seen_low, got_done, err_seen, flag;
    vec_t v;

    n_chk = 0; n_fail = 0;
    vecs[0] = '{req: 3'b001, len: 4'd1,  tx: 8'hA5, resp: 8'h3C, exp_grant: 3'b001, exp_rx: 8'h3C};
    vecs[1] = '{req: 3'b010, len: 4'd3,  tx: 8'h01, resp: 8'h50, exp_grant: 3'b010, exp_rx: 8'h52};
    vecs[2] = '{req: 3'b100, len: 4'd0,  tx: 8'h77, resp: 8'h00, exp_grant: 3'b000, exp_rx: 8'h52};
    vecs[3] = '{req: 3'b100, len: 4'd2,  tx: 8'hF0, resp: 8'hC8, exp_grant: 3'b100, exp_rx: 8'hC9};
    vecs[4] = '{req: 3'b001, len: 4'd15, tx: 8'h10, resp: 8'hE0, exp_grant: 3'b001, exp_rx: 8'hEE};

    rst = 1'b1; req = '0; req_len = '0; req_tx = '0; slave_resp = '0; slave_mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'h7);
    chk("rst_byte_done", 32'(byte_done), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_spi_data_in", 32'(spi_data_in), 32'd0);
    rst = 1'b0;

    for (int unsigned i = 0; i < 5; i++) run_vec(vecs[i]);

    // All three requesting at once from a fresh pointer.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    req_len = {NREQ{4'd1}}; req_tx = {NREQ{8'h11}}; slave_resp = 8'h22;
    req = 3'b111;
    ng = 0; nd = 0; run = 0; min_gap = 1000; seen_low = 0; prev_g = '0;
    for (int unsigned i = 0; i < 4; i++) order[i] = '0;
    for (int unsigned cyc = 0; cyc < 300 && nd < 4; cyc++) begin
      @(negedge clk);
      if (grant != '0 && prev_g == '0) begin
        if (ng < 4) order[ng] = grant;
        ng++;
        if (ng >= 4) req = '0;
      end
      prev_g = grant;
      if (cs_n == '1) begin
        if (seen_low) run++;
      end else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        run = 0;
        seen_low = 1'b1;
      end
      if (done) nd++;
    end
    chk("rr_order_0", 32'(order[0]), 32'h1);
    chk("rr_order_1", 32'(order[1]), 32'h2);
    chk("rr_order_2", 32'(order[2]), 32'h4);
    chk("rr_order_3", 32'(order[3]), 32'h1);
    chk("rr_bursts_done", nd, 32'd4);
    chk("rr_min_gap_ok", 32'(min_gap >= GAP), 32'd1);
    repeat (4) @(negedge clk);

    // Watchdog abort: engine never answers.
    slave_mute = 1'b1;
    req_len = {NREQ{4'd2}}; req_tx = {NREQ{8'h33}};
    req = 3'b010;
    starts = 0; bds = 0; t_st = 0; t_done = 0; got_done = 0; err_seen = 0;
    for (int unsigned cyc = 1; cyc <= 400 && !got_done; cyc++) begin
      @(negedge clk);
      if (grant != '0) req = '0;
      if (spi_start) begin if (starts == 0) t_st = cyc; starts++; end
      if (byte_done) bds++;
      if (done) begin got_done = 1'b1; t_done = cyc; err_seen = err; end
    end
    chk("tmo_done_seen", 32'(got_done), 32'd1);
    chk("tmo_latency", t_done - t_st, 32'd255);
    chk("tmo_err", 32'(err_seen), 32'd1);
    chk("tmo_starts", starts, 32'd1);
    chk("tmo_byte_done", bds, 32'd0);
    @(negedge clk);
    chk("tmo_cs_released", 32'(cs_n), 32'h7);
    chk("tmo_err_pulse", 32'(err), 32'd0);
    slave_mute = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during the second byte of a three-byte burst.
    req_len = {NREQ{4'd3}}; req_tx = {NREQ{8'h40}}; slave_resp = 8'h90;
    req = 3'b001;
    starts = 0;
    for (int unsigned cyc = 0; cyc < 100 && starts < 2; cyc++) begin
      @(negedge clk);
      if (grant != '0) req = '0;
      if (spi_start) starts++;
    end
    chk("mid_rst_reached_byte2", starts, 32'd2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", 32'(cs_n), 32'h7);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_byte_done", 32'(byte_done), 32'd0);
    chk("mid_rst_spi_start", 32'(spi_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || byte_done || cs_n != '1 || spi_start) flag = 1'b1;
    end
    chk("post_rst_quiet", 32'(flag), 32'd0);
    v = '{req: 3'b001, len: 4'd1, tx: 8'h5A, resp: 8'h66, exp_grant: 3'b001, exp_rx: 8'h66};
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
